// File: rtl/core_defs.sv
// Shared front-end definitions: datapath width, the canonical NOP and the
// pipeline-control state encoding.
package core_defs;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PEND     = 2'd1,
    DRAIN    = 2'd2,
    TRAP_JMP = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Front-end pipeline control: arbitrates trap/mret/branch redirects and
// fetch/load-store stalls into PC jump/hold and IF/ID, ID/EX hold/flush.
module pipe_ctrl
  import core_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_jump_flag_in,
  input  logic [XLEN-1:0] ex_jump_addr_in,
  input  logic            mret_flag_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            trap_req_in,
  input  logic [XLEN-1:0] trap_vec_in,
  input  logic            ifu_stall_in,
  input  logic            lsu_stall_in,
  output logic            trap_ack_out,
  output logic            pc_jump_flag_out,
  output logic [XLEN-1:0] pc_jump_addr_out,
  output logic            pc_hold_flag_out,
  output logic            hold_if_id_out,
  output logic            hold_id_ex_out,
  output logic            flush_if_id_out,
  output logic            flush_id_ex_out
);

  pc_state_e       state, state_nxt;
  logic [XLEN-1:0] pend_addr_q, trap_vec_q;
  logic            cap_pend, cap_trap;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;

  // mret outranks a same-cycle branch; both are redirects of equal kind otherwise.
  assign redirect      = mret_flag_in | ex_jump_flag_in;
  assign redirect_addr = mret_flag_in ? mepc_in : ex_jump_addr_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      pend_addr_q <= '0;
      trap_vec_q  <= '0;
    end else begin
      state <= state_nxt;
      if (cap_pend) pend_addr_q <= redirect_addr;
      if (cap_trap) trap_vec_q  <= trap_vec_in;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would infer a latch.
    state_nxt        = state;
    cap_pend         = 1'b0;
    cap_trap         = 1'b0;
    trap_ack_out     = 1'b0;
    pc_jump_flag_out = 1'b0;
    pc_jump_addr_out = RESET_VEC;
    pc_hold_flag_out = 1'b0;
    hold_if_id_out   = 1'b0;
    hold_id_ex_out   = 1'b0;
    flush_if_id_out  = 1'b0;
    flush_id_ex_out  = 1'b0;

    unique case (state)
      RUN, PEND: begin
        if (trap_req_in) begin
          // Trap acceptance: freeze fetch and drop whatever redirect was pending.
          cap_trap         = 1'b1;
          state_nxt        = DRAIN;
          pc_hold_flag_out = 1'b1;
          hold_if_id_out   = 1'b1;
          flush_id_ex_out  = 1'b1;
        end else if (state == PEND) begin
          if (ifu_stall_in) begin
            pc_hold_flag_out = 1'b1;
            hold_if_id_out   = 1'b1;
          end else begin
            pc_jump_flag_out = 1'b1;
            pc_jump_addr_out = pend_addr_q;
            flush_if_id_out  = 1'b1;
            state_nxt        = RUN;
          end
        end else if (redirect) begin
          flush_if_id_out = 1'b1;
          flush_id_ex_out = 1'b1;
          if (ifu_stall_in) begin
            cap_pend         = 1'b1;
            pc_hold_flag_out = 1'b1;
            state_nxt        = PEND;
          end else begin
            pc_jump_flag_out = 1'b1;
            pc_jump_addr_out = redirect_addr;
          end
        end else begin
          pc_hold_flag_out = ifu_stall_in | lsu_stall_in;
          hold_if_id_out   = ifu_stall_in | lsu_stall_in;
          hold_id_ex_out   = lsu_stall_in;
          flush_id_ex_out  = ifu_stall_in & ~lsu_stall_in;
        end
      end
      DRAIN: begin
        pc_hold_flag_out = 1'b1;
        hold_if_id_out   = 1'b1;
        flush_id_ex_out  = 1'b1;
        if (!lsu_stall_in && !ifu_stall_in) state_nxt = TRAP_JMP;
      end
      TRAP_JMP: begin
        pc_jump_flag_out = 1'b1;
        pc_jump_addr_out = trap_vec_q;
        flush_if_id_out  = 1'b1;
        flush_id_ex_out  = 1'b1;
        trap_ack_out     = 1'b1;
        state_nxt        = RUN;
      end
      default: state_nxt = RUN;
    endcase

    // A jump beats a hold on the PC; a flush beats a hold on the same register.
    if (pc_jump_flag_out) pc_hold_flag_out = 1'b0;
    if (flush_if_id_out)  hold_if_id_out   = 1'b0;
    if (flush_id_ex_out)  hold_id_ex_out   = 1'b0;

    if (!rst) begin
      trap_ack_out     = 1'b0;
      pc_jump_flag_out = 1'b0;
      pc_jump_addr_out = RESET_VEC;
      pc_hold_flag_out = 1'b0;
      hold_if_id_out   = 1'b0;
      hold_id_ex_out   = 1'b0;
      flush_if_id_out  = 1'b0;
      flush_id_ex_out  = 1'b0;
    end
  end

endmodule
